// File: rtl/iq_4interp.sv
// iq_4interp: interpolate-by-4 I/Q block.
// One strobed input sample becomes four output samples, one per strobe_req tick.
// The output is scaled by 1/4, which keeps a decimate-by-4 summing stage
// followed by this block at unity gain.
//
// Build option IQ_4INTERP_LINEAR_EN:
//   undefined - zero-order hold, out = active >>> 2
//   defined   - linear interpolation between the previous and the current
//               held sample, out_k = (prev*(4-k) + active*k) >>> 4
// Ports, latency and flag behaviour are the same in both builds.
//
// Handshake: strobe_in and strobe_req are one-cycle pulses qualified by ce;
// strobe_out is a one-cycle pulse, high exactly one clk after a qualified
// strobe_req, and I_out/Q_out are valid while it is high and hold afterwards.
// There is no backpressure: an unconsumed pending sample is overwritten (overrun)
// and a period that starts with nothing pending emits zeros (underrun).

module iq_4interp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         strobe_in,
  input  logic signed [DATA_WIDTH-1:0] I_in,
  input  logic signed [DATA_WIDTH-1:0] Q_in,
  input  logic                         strobe_req,
  output logic signed [DATA_WIDTH-1:0] I_out,
  output logic signed [DATA_WIDTH-1:0] Q_out,
  output logic                         strobe_out,
  output logic                         underrun,
  output logic                         overrun
);

  // Input buffer, sample being emitted, and output-rate phase.
  logic signed [DATA_WIDTH-1:0] r_pend_i;
  logic signed [DATA_WIDTH-1:0] r_pend_q;
  logic                         r_pend_valid;
  logic signed [DATA_WIDTH-1:0] r_act_i;
  logic signed [DATA_WIDTH-1:0] r_act_q;
  logic [1:0]                   r_phase;

  // Registered outputs.
  logic signed [DATA_WIDTH-1:0] r_i_out;
  logic signed [DATA_WIDTH-1:0] r_q_out;
  logic                         r_strobe_out;
  logic                         r_underrun;
  logic                         r_overrun;

  // Qualified events for this cycle.
  logic w_req;
  logic w_cap;
  logic w_period_start;

  // Active value as it will be after this cycle; the output of a strobe_req
  // uses the active register as updated by that same strobe_req.
  logic signed [DATA_WIDTH-1:0] w_next_act_i;
  logic signed [DATA_WIDTH-1:0] w_next_act_q;

  // Output sample computed for the current phase.
  logic signed [DATA_WIDTH-1:0] w_out_i;
  logic signed [DATA_WIDTH-1:0] w_out_q;

  assign w_req          = ce & strobe_req;
  assign w_cap          = ce & strobe_in;
  assign w_period_start = w_req & (r_phase == 2'd0);

  // Select the sample that will be active: pending at a period start,
  // zeros on an underrun, otherwise unchanged.
  always_comb begin
    w_next_act_i = r_act_i;
    w_next_act_q = r_act_q;
    if (w_period_start) begin
      if (r_pend_valid) begin
        w_next_act_i = r_pend_i;
        w_next_act_q = r_pend_q;
      end else begin
        w_next_act_i = '0;
        w_next_act_q = '0;
      end
    end
  end

`ifdef IQ_4INTERP_LINEAR_EN
  // Previously active sample, the start point of the interpolation ramp.
  logic signed [DATA_WIDTH-1:0] r_prev_i;
  logic signed [DATA_WIDTH-1:0] r_prev_q;
  logic signed [DATA_WIDTH-1:0] w_next_prev_i;
  logic signed [DATA_WIDTH-1:0] w_next_prev_q;

  // (prev*(4-k) + act*k) >>> 4 at DATA_WIDTH+3 bits; weights sum to 4 so the
  // shifted result always fits back into DATA_WIDTH bits.
  function automatic logic signed [DATA_WIDTH-1:0] lerp4(
    input logic signed [DATA_WIDTH-1:0] p,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic [1:0]                   k
  );
    logic signed [DATA_WIDTH+2:0] pe;
    logic signed [DATA_WIDTH+2:0] ae;
    logic signed [DATA_WIDTH+2:0] sum;
    logic signed [DATA_WIDTH+2:0] shifted;
    pe = {{3{p[DATA_WIDTH-1]}}, p};
    ae = {{3{a[DATA_WIDTH-1]}}, a};
    case (k)
      2'd0:    sum = pe <<< 2;
      2'd1:    sum = (pe <<< 1) + pe + ae;
      2'd2:    sum = (pe <<< 1) + (ae <<< 1);
      default: sum = pe + (ae <<< 1) + ae;
    endcase
    shifted = sum >>> 4;
    return shifted[DATA_WIDTH-1:0];
  endfunction

  // prev takes the old active value at each period start.
  always_comb begin
    w_next_prev_i = r_prev_i;
    w_next_prev_q = r_prev_q;
    if (w_period_start) begin
      w_next_prev_i = r_act_i;
      w_next_prev_q = r_act_q;
    end
  end

  // Interpolated output for the phase in effect at this strobe_req.
  always_comb begin
    w_out_i = lerp4(w_next_prev_i, w_next_act_i, r_phase);
    w_out_q = lerp4(w_next_prev_q, w_next_act_q, r_phase);
  end

  // prev register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_i <= '0;
      r_prev_q <= '0;
    end else begin
      r_prev_i <= w_next_prev_i;
      r_prev_q <= w_next_prev_q;
    end
  end
`else
  // Zero-order hold scaled by 1/4 (arithmetic shift, floor rounding).
  always_comb begin
    w_out_i = w_next_act_i >>> 2;
    w_out_q = w_next_act_q >>> 2;
  end
`endif

  // Input buffer: capture on strobe_in, release at a period start. A capture
  // coinciding with a period start refills the buffer in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_i     <= '0;
      r_pend_q     <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_cap) begin
      r_pend_i     <= I_in;
      r_pend_q     <= Q_in;
      r_pend_valid <= 1'b1;
    end else if (w_period_start) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Active sample and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_i <= '0;
      r_act_q <= '0;
      r_phase <= 2'd0;
    end else begin
      r_act_i <= w_next_act_i;
      r_act_q <= w_next_act_q;
      if (w_req) r_phase <= r_phase + 2'd1;
    end
  end

  // Output samples and one-cycle pulses; pulses drop to 0 whenever no
  // qualified event occurred, including every cycle with ce=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_out      <= '0;
      r_q_out      <= '0;
      r_strobe_out <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_strobe_out <= w_req;
      r_underrun   <= w_period_start & ~r_pend_valid;
      r_overrun    <= w_cap & r_pend_valid & ~w_period_start;
      if (w_req) begin
        r_i_out <= w_out_i;
        r_q_out <= w_out_q;
      end
    end
  end

  assign I_out      = r_i_out;
  assign Q_out      = r_q_out;
  assign strobe_out = r_strobe_out;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_iq_4interp.sv
// Directed testbench for iq_4interp.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at that
// same point, i.e. well away from the active edge.

module tb_iq_4interp;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ce;
  logic                 strobe_in;
  logic signed [DW-1:0] I_in;
  logic signed [DW-1:0] Q_in;
  logic                 strobe_req;
  logic signed [DW-1:0] I_out;
  logic signed [DW-1:0] Q_out;
  logic                 strobe_out;
  logic                 underrun;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  iq_4interp #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .strobe_in  (strobe_in),
    .I_in       (I_in),
    .Q_in       (Q_in),
    .strobe_req (strobe_req),
    .I_out      (I_out),
    .Q_out      (Q_out),
    .strobe_out (strobe_out),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    strobe_in = 1'b0;
    strobe_req = 1'b0;
    ce = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  // Driver tasks.
  task automatic strobe_sample(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    strobe_in = 1'b1;
    I_in = i;
    Q_in = q;
    tick();
    strobe_in = 1'b0;
  endtask

  task automatic req(input logic sin, input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    strobe_req = 1'b1;
    strobe_in = sin;
    I_in = i;
    Q_in = q;
    tick();
    strobe_req = 1'b0;
    strobe_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    strobe_sample(16, -16);
    req(1'b0, 0, 0);
    idle(2);
    req(1'b0, 0, 0);
    idle(2);
    strobe_sample(16, -16);
    // phase is now 2 with a pending sample; assert reset between edges
    #3 rst = 1'b1;
    #1;
    checks++;
    if (I_out !== 0 || Q_out !== 0 || strobe_out !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: I_out=%0d Q_out=%0d strobe_out=%b underrun=%b overrun=%b required all 0",
               I_out, Q_out, strobe_out, underrun, overrun);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    checks++;
    if (I_out !== 0 || Q_out !== 0 || strobe_out !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: I_out=%0d Q_out=%0d strobe_out=%b underrun=%b overrun=%b required all 0",
               I_out, Q_out, strobe_out, underrun, overrun);
    end
    req(1'b0, 0, 0);
    checks++;
    if (strobe_out !== 1'b1 || underrun !== 1'b1 || overrun !== 1'b0 || I_out !== 0 || Q_out !== 0) begin
      errors++;
      $display("FAIL reset_first_req: strobe_out=%b underrun=%b overrun=%b I_out=%0d Q_out=%0d required 1 1 0 0 0",
               strobe_out, underrun, overrun, I_out, Q_out);
    end
    tick();
    checks++;
    if (strobe_out !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse_width: strobe_out=%b underrun=%b required 0 0", strobe_out, underrun);
    end
  endtask

  task automatic test_hold();
    do_reset();
    strobe_sample(16, -16);
    idle(8);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        req(1'b0, 0, 0);
        checks++;
        if (strobe_out !== 1'b1 || I_out !== 16'sd4 || Q_out !== -16'sd4) begin
          errors++;
          $display("FAIL hold p%0d k%0d: strobe_out=%b I_out=%0d Q_out=%0d required 1 4 -4",
                   p, k, strobe_out, I_out, Q_out);
        end
        checks++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL hold_flags p%0d k%0d: underrun=%b overrun=%b required 0 0", p, k, underrun, overrun);
        end
        tick();
        checks++;
        if (strobe_out !== 1'b0) begin
          errors++;
          $display("FAIL hold_strobe_width p%0d k%0d: strobe_out=%b required 0", p, k, strobe_out);
        end
        idle(7);
        if (k == 3) strobe_sample(16, -16);
        else tick();
      end
    end
  endtask

  task automatic test_rounding();
    do_reset();
    strobe_sample(-17, 17);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      // k=2 also captures a new sample, which must not disturb this period
      req(k == 2, 16, -16);
      checks++;
      if (strobe_out !== 1'b1 || I_out !== -16'sd5 || Q_out !== 16'sd4 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL rounding k%0d: strobe_out=%b I_out=%0d Q_out=%0d overrun=%b required 1 -5 4 0",
                 k, strobe_out, I_out, Q_out, overrun);
      end
      idle(2);
    end
    req(1'b0, 0, 0);
    checks++;
    if (I_out !== 16'sd4 || Q_out !== -16'sd4 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL rounding_next: I_out=%0d Q_out=%0d underrun=%b required 4 -4 0", I_out, Q_out, underrun);
    end
  endtask

  task automatic test_flags();
    do_reset();
    strobe_sample(16, -16);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      req(1'b0, 0, 0);
      checks++;
      if (I_out !== 16'sd4 || Q_out !== -16'sd4 || underrun !== 1'b0) begin
        errors++;
        $display("FAIL flags_prime k%0d: I_out=%0d Q_out=%0d underrun=%b required 4 -4 0", k, I_out, Q_out, underrun);
      end
      idle(3);
    end
    // no new sample: underrun at phase 0, zeros out
    req(1'b0, 0, 0);
    checks++;
    if (strobe_out !== 1'b1 || underrun !== 1'b1 || I_out !== 0 || Q_out !== 0) begin
      errors++;
      $display("FAIL underrun: strobe_out=%b underrun=%b I_out=%0d Q_out=%0d required 1 1 0 0",
               strobe_out, underrun, I_out, Q_out);
    end
    tick();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_width: underrun=%b required 0", underrun);
    end
    for (int k = 1; k < 4; k++) begin
      req(1'b0, 0, 0);
      checks++;
      if (I_out !== 0 || Q_out !== 0 || underrun !== 1'b0) begin
        errors++;
        $display("FAIL underrun_tail k%0d: I_out=%0d Q_out=%0d underrun=%b required 0 0 0", k, I_out, Q_out, underrun);
      end
      idle(2);
    end
    // two samples before phase 0: overrun, second sample wins
    strobe_sample(8, -8);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: overrun=%b required 0", overrun);
    end
    strobe_sample(40, -40);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_second: overrun=%b required 1", overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_width: overrun=%b required 0", overrun);
    end
    for (int k = 0; k < 4; k++) begin
      req(1'b0, 0, 0);
      checks++;
      if (I_out !== 16'sd10 || Q_out !== -16'sd10 || underrun !== 1'b0) begin
        errors++;
        $display("FAIL overrun_value k%0d: I_out=%0d Q_out=%0d underrun=%b required 10 -10 0", k, I_out, Q_out, underrun);
      end
      idle(2);
    end
    // capture coincident with period start: pending moves on, new one stays
    strobe_sample(20, -20);
    tick();
    req(1'b1, 80, -80);
    checks++;
    if (I_out !== 16'sd5 || Q_out !== -16'sd5 || underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coincident: I_out=%0d Q_out=%0d underrun=%b overrun=%b required 5 -5 0 0",
               I_out, Q_out, underrun, overrun);
    end
    idle(2);
    for (int k = 1; k < 4; k++) begin
      req(1'b0, 0, 0);
      checks++;
      if (I_out !== 16'sd5 || Q_out !== -16'sd5) begin
        errors++;
        $display("FAIL coincident_tail k%0d: I_out=%0d Q_out=%0d required 5 -5", k, I_out, Q_out);
      end
      idle(2);
    end
    req(1'b0, 0, 0);
    checks++;
    if (I_out !== 16'sd20 || Q_out !== -16'sd20 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL coincident_kept: I_out=%0d Q_out=%0d underrun=%b required 20 -20 0", I_out, Q_out, underrun);
    end
  endtask

  task automatic test_ce();
    do_reset();
    strobe_sample(16, -16);
    idle(2);
    req(1'b0, 0, 0);
    idle(2);
    req(1'b0, 0, 0);
    idle(2);
    // phase 2, nothing pending; toggle strobes with ce low
    ce = 1'b0;
    for (int i = 0; i < 40; i++) begin
      strobe_req = i[0];
      strobe_in = ~i[0];
      I_in = 100;
      Q_in = -100;
      tick();
      checks++;
      if (strobe_out !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0 || I_out !== 16'sd4 || Q_out !== -16'sd4) begin
        errors++;
        $display("FAIL ce_hold c%0d: strobe_out=%b underrun=%b overrun=%b I_out=%0d Q_out=%0d required 0 0 0 4 -4",
                 i, strobe_out, underrun, overrun, I_out, Q_out);
      end
    end
    strobe_req = 1'b0;
    strobe_in = 1'b0;
    ce = 1'b1;
    tick();
    req(1'b0, 0, 0);
    checks++;
    if (strobe_out !== 1'b1 || I_out !== 16'sd4 || Q_out !== -16'sd4 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ce_resume_p2: strobe_out=%b I_out=%0d Q_out=%0d underrun=%b required 1 4 -4 0",
               strobe_out, I_out, Q_out, underrun);
    end
    idle(2);
    req(1'b0, 0, 0);
    checks++;
    if (I_out !== 16'sd4 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ce_resume_p3: I_out=%0d underrun=%b required 4 0", I_out, underrun);
    end
    idle(2);
    req(1'b0, 0, 0);
    checks++;
    if (underrun !== 1'b1 || I_out !== 0 || Q_out !== 0) begin
      errors++;
      $display("FAIL ce_resume_p0: underrun=%b I_out=%0d Q_out=%0d required 1 0 0", underrun, I_out, Q_out);
    end
  endtask

`ifdef IQ_4INTERP_LINEAR_EN
  task automatic test_linear();
    logic signed [DW-1:0] exp_i [12];
    exp_i = '{0, 0, 0, 0, 0, 4, 8, 12, 16, 16, 16, 16};
    do_reset();
    strobe_sample(0, 0);
    idle(2);
    for (int n = 0; n < 12; n++) begin
      req(1'b0, 0, 0);
      checks++;
      if (strobe_out !== 1'b1 || I_out !== exp_i[n] || Q_out !== -exp_i[n] || underrun !== 1'b0) begin
        errors++;
        $display("FAIL linear n%0d: strobe_out=%b I_out=%0d Q_out=%0d underrun=%b required 1 %0d %0d 0",
                 n, strobe_out, I_out, Q_out, underrun, exp_i[n], -exp_i[n]);
      end
      idle(2);
      if (n % 4 == 3) strobe_sample(64, -64);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    strobe_in = 1'b0;
    strobe_req = 1'b0;
    I_in = '0;
    Q_in = '0;
    test_reset();
`ifdef IQ_4INTERP_LINEAR_EN
    test_linear();
`else
    test_hold();
    test_rounding();
    test_flags();
    test_ce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
